spi_slave_frame_ctrl: RTL and testbench
=======================================

// Module: spi_slave_frame_ctrl
// PURPOSE
//   SPI slave front end for the traffic-light register file. It deserialises
//   MOSI command frames on spi_sclk and drives the write port (addr/data/wen)
//   and the read handshake port (r_en/r_addr, r_data/ren_ack) of the register
//   file. It returns read data on MISO within the same frame.
// PARAMETERS
//   ADDR_W        2   register address width
//   DATA_W        3   register data width
//   FRAME_LEN     16  bits per frame: 8 command + 8 response
//   ACK_DEADLINE  12  bit count by which ren_ack must have been seen on a read
// PORTS
//   spi_sclk  in   1       SPI clock; every flop updates on posedge
//   n_rst     in   1       asynchronous, active-low reset
//   spi_cs_n  in   1       chip select, active low, sampled on posedge spi_sclk
//   spi_mosi  in   1       serial command in, MSB first
//   spi_miso  out  1       serial response out, registered
//   addr      out  ADDR_W  write address to regfile
//   data      out  DATA_W  write data to regfile
//   wen       out  1       write strobe, single-cycle pulse
//   r_en      out  1       read request, level, held until acked
//   r_addr    out  ADDR_W  read address, stable while r_en=1
//   r_data    in   DATA_W  read data from regfile, valid when ren_ack=1
//   ren_ack   in   1       read acknowledge from regfile
//   frame_err out  1       sticky per frame: bad reserved bits or ack timeout
// BEHAVIOUR
//   Reset: all outputs are 0, bit counter is 0, state is IDLE.
//   Command byte (bits 0..7, MSB first): [7] 1=write/0=read, [6:5] addr,
//     [4:3] reserved and must be 00, [2:0] data (ignored on read).
//   States: IDLE -> CMD (first posedge with cs_n=0) -> WR | RD_WAIT | ERR -> DRAIN.
//     Any posedge with cs_n=1 forces IDLE, clears bit_cnt and drives miso=0.
//     bit_cnt increments once per posedge in a frame and saturates at FRAME_LEN.
//   Frame start (IDLE and cs_n=0): frame_err clears and bit 0 is captured.
//   On the edge that captures bit 7:
//     - If reserved bits are non-zero: frame_err=1, no wen/r_en, go to DRAIN.
//     - Write: addr and data are registered and wen=1 for exactly one cycle
//       (visible after that edge). Then go to DRAIN.
//     - Read: r_addr=cmd[6:5] and r_en=1. Go to RD_WAIT.
//   RD_WAIT: on the first edge sampling ren_ack=1, capture r_data into rd_sh
//     and set r_en=0 on the same edge.
//     If bit_cnt reaches ACK_DEADLINE with no ack: r_en=0, frame_err=1,
//     rd_sh=0.
//     Expected latency is 3 edges from r_en to ack, i.e. ack sampled at bit ~11.
//   MISO: drives 0 for bits 0..12. Bits 13,14,15 carry rd_sh[2],[1],[0]
//     (zero-padded byte {5'b0, r_data}). A bit is updated on the posedge
//     ending the previous bit; the master samples on the next posedge.
//   Bits beyond 15: ignored, miso=0, no further strobes until cs_n goes high.
//   cs_n high before bit 7 is captured: no wen/r_en is issued.
//   cs_n high while r_en=1: r_en drops next edge and a late ack is ignored.
//   wen and r_en are never both 1.
//   Asynchronous reset mid-frame: immediate return to reset values.
//   The host guarantees at least 2 sclk edges with cs_n=1 between frames.
// STRUCTURE
//   Shared package/include spi_tl_defs: FRAME_LEN, CMD_LEN=8, opcode bit
//     indices (CMD_RW=7, CMD_ADDR=6:5, CMD_RSV=4:3, CMD_DATA=2:0), state
//     encodings, and register addresses A_T_R_WAIT=0, A_T_G_WAIT=1.
//   Single module, no sub-modules: shift register, bit counter, 5-state FSM,
//     and MISO output register.
// TESTING
//   1 Write 0xA5 (1_01_00_101) -> one-cycle wen after bit-7 edge, addr=1,
//     data=5. No r_en. frame_err=0.
//   2 Read 0x20 (addr=1), regfile model acks 3 edges after r_en with r_data=3
//     -> r_en high for 3 cycles then 0. MISO bits 13..15 = 0,1,1. frame_err=0.
//   3 Frame 0x88 (reserved=01) -> frame_err=1, no wen, no r_en, MISO all 0.
//     The next valid frame clears frame_err.
//   4 cs_n raised after bit 4 of 0xA5 -> no wen. The next frame 0x81 writes
//     addr=0, data=1 correctly.
//   5 Read with ack never returned -> r_en drops at bit 12, frame_err=1,
//     MISO bits 13..15 = 0.
//   6 n_rst pulsed during RD_WAIT -> all outputs 0 at once. The next full read
//     frame completes normally.

Source files
------------

// File: rtl/spi_tl_defs.sv
// Shared frame layout, opcode bit positions and FSM encoding for the
// traffic-light SPI slave.
package spi_tl_defs;
   localparam int FRAME_LEN   = 16;
   localparam int CMD_LEN     = 8;
   localparam int CNT_W       = $clog2(FRAME_LEN + 1);

   localparam int CMD_RW      = 7;
   localparam int CMD_ADDR_HI = 6;
   localparam int CMD_ADDR_LO = 5;
   localparam int CMD_RSV_HI  = 4;
   localparam int CMD_RSV_LO  = 3;
   localparam int CMD_DATA_HI = 2;
   localparam int CMD_DATA_LO = 0;

   localparam logic [1:0] A_T_R_WAIT = 2'd0;
   localparam logic [1:0] A_T_G_WAIT = 2'd1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_WR      = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_DRAIN   = 3'd4
   } state_t;
endpackage

// File: rtl/spi_slave_frame_ctrl.sv
// SPI slave front end: decodes 8-bit command frames into regfile write strobes
// and read handshakes, returning read data on MISO in the last bits of the frame.
module spi_slave_frame_ctrl
   import spi_tl_defs::*;
#(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 3,
   parameter int ACK_DEADLINE = 12
) (
   input  logic              spi_sclk,
   input  logic              n_rst,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              wen,
   output logic              r_en,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   input  logic              ren_ack,
   output logic              frame_err
);

   localparam logic [CNT_W-1:0] CNT_LAST_CMD  = CNT_W'(CMD_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_CMD_LEN   = CNT_W'(CMD_LEN);
   localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_ACK_LAST  = CNT_W'(ACK_DEADLINE - 1);
   localparam logic [CNT_W-1:0] CNT_MISO_LOAD = CNT_W'(FRAME_LEN - DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MISO_END  = CNT_W'(FRAME_LEN - 1);

   state_t              state_q, state_nxt;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
   logic [CMD_LEN-1:0]  cmd_sh, cmd_sh_nxt, cmd_full;
   logic [DATA_W-1:0]   rd_sh, rd_sh_nxt;
   logic [ADDR_W-1:0]   addr_nxt, r_addr_nxt;
   logic [DATA_W-1:0]   data_nxt;
   logic                wen_nxt, r_en_nxt, miso_nxt, frame_err_nxt;

   assign cmd_full = {cmd_sh[CMD_LEN-2:0], spi_mosi};

   always_ff @(posedge spi_sclk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= ST_IDLE;
         bit_cnt   <= '0;
         cmd_sh    <= '0;
         rd_sh     <= '0;
         addr      <= '0;
         data      <= '0;
         wen       <= 1'b0;
         r_en      <= 1'b0;
         r_addr    <= '0;
         spi_miso  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         cmd_sh    <= cmd_sh_nxt;
         rd_sh     <= rd_sh_nxt;
         addr      <= addr_nxt;
         data      <= data_nxt;
         wen       <= wen_nxt;
         r_en      <= r_en_nxt;
         r_addr    <= r_addr_nxt;
         spi_miso  <= miso_nxt;
         frame_err <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      bit_cnt_nxt   = bit_cnt;
      cmd_sh_nxt    = cmd_sh;
      rd_sh_nxt     = rd_sh;
      addr_nxt      = addr;
      data_nxt      = data;
      wen_nxt       = 1'b0;
      r_en_nxt      = r_en;
      r_addr_nxt    = r_addr;
      miso_nxt      = 1'b0;
      frame_err_nxt = frame_err;

      if (spi_cs_n) begin
         state_nxt   = ST_IDLE;
         bit_cnt_nxt = '0;
         r_en_nxt    = 1'b0;
      end else begin
         if (bit_cnt != CNT_FULL)
            bit_cnt_nxt = bit_cnt + 1'b1;
         if (bit_cnt < CNT_CMD_LEN)
            cmd_sh_nxt = cmd_full;

         case (state_q)
            ST_IDLE: begin
               frame_err_nxt = 1'b0;
               rd_sh_nxt     = '0;
               state_nxt     = ST_CMD;
            end
            ST_CMD: begin
               if (bit_cnt == CNT_LAST_CMD) begin
                  if (cmd_full[CMD_RSV_HI:CMD_RSV_LO] != '0) begin
                     frame_err_nxt = 1'b1;
                     state_nxt     = ST_DRAIN;
                  end else if (cmd_full[CMD_RW]) begin
                     addr_nxt  = cmd_full[CMD_ADDR_HI:CMD_ADDR_LO];
                     data_nxt  = cmd_full[CMD_DATA_HI:CMD_DATA_LO];
                     wen_nxt   = 1'b1;
                     state_nxt = ST_WR;
                  end else begin
                     r_addr_nxt = cmd_full[CMD_ADDR_HI:CMD_ADDR_LO];
                     r_en_nxt   = 1'b1;
                     state_nxt  = ST_RD_WAIT;
                  end
               end
            end
            ST_WR: state_nxt = ST_DRAIN;
            ST_RD_WAIT: begin
               // An ack on the deadline edge still wins over the timeout.
               if (ren_ack) begin
                  rd_sh_nxt = r_data;
                  r_en_nxt  = 1'b0;
                  state_nxt = ST_DRAIN;
               end else if (bit_cnt == CNT_ACK_LAST) begin
                  rd_sh_nxt     = '0;
                  r_en_nxt      = 1'b0;
                  frame_err_nxt = 1'b1;
                  state_nxt     = ST_DRAIN;
               end
            end
            default: state_nxt = ST_DRAIN;
         endcase

         // Response bits are launched one edge ahead of the master's sample edge.
         if (bit_cnt >= CNT_MISO_LOAD && bit_cnt < CNT_MISO_END) begin
            miso_nxt  = rd_sh[DATA_W-1];
            rd_sh_nxt = {rd_sh[DATA_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_frame_ctrl.sv
// Bench for spi_slave_frame_ctrl: frame-level scoreboard plus a regfile ack model.
module tb_spi_slave_frame_ctrl;

   typedef struct packed {
      logic [3:0] wen_n;
      logic [4:0] wen_idx;
      logic [1:0] waddr;
      logic [2:0] wdata;
      logic [4:0] ren_n;
      logic [1:0] raddr;
      logic [7:0] miso_b;
      logic       err;
      logic       both;
   } res_t;

   logic       spi_sclk = 1'b0;
   logic       n_rst    = 1'b0;
   logic       spi_cs_n = 1'b1;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic [1:0] addr;
   logic [2:0] data;
   logic       wen;
   logic       r_en;
   logic [1:0] r_addr;
   logic [2:0] r_data   = 3'd0;
   logic       ren_ack  = 1'b0;
   logic       frame_err;

   logic       ack_on   = 1'b0;
   int         ack_cnt  = 0;
   int         n_checks = 0;
   int         n_pass   = 0;
   res_t       exp_q[$];
   res_t       obs, exp_r;

   spi_slave_frame_ctrl dut (
      .spi_sclk (spi_sclk),
      .n_rst    (n_rst),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .addr     (addr),
      .data     (data),
      .wen      (wen),
      .r_en     (r_en),
      .r_addr   (r_addr),
      .r_data   (r_data),
      .ren_ack  (ren_ack),
      .frame_err(frame_err)
   );

   always #5 spi_sclk = ~spi_sclk;

   // Regfile model: ack is sampled on the third edge that sees r_en high.
   always @(negedge spi_sclk) begin
      if (!ack_on || !r_en) begin
         ack_cnt = 0;
         ren_ack = 1'b0;
      end else begin
         ack_cnt = ack_cnt + 1;
         ren_ack = (ack_cnt == 3);
      end
   end

   task automatic run_frame(input logic [7:0] cmd, input int nbits, output res_t r);
      r = '0;
      for (int i = 0; i <= nbits; i++) begin
         @(negedge spi_sclk);
         if (wen) begin
            r.wen_n   = r.wen_n + 4'd1;
            r.wen_idx = 5'(i);
            r.waddr   = addr;
            r.wdata   = data;
         end
         if (r_en) begin
            r.ren_n = r.ren_n + 5'd1;
            r.raddr = r_addr;
         end
         if (wen && r_en) r.both = 1'b1;
         if (i >= 8 && i < 16) r.miso_b[15-i] = spi_miso;
         if (i == nbits) begin
            r.err    = frame_err;
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
         end else begin
            spi_cs_n = 1'b0;
            spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
         end
      end
      repeat (2) @(negedge spi_sclk);
   endtask

   function automatic res_t mk(input int wn, input int widx, input int wa, input int wd,
                               input int rn, input int ra, input int mb, input int er);
      res_t e;
      e        = '0;
      e.wen_n  = 4'(wn);
      e.wen_idx= 5'(widx);
      e.waddr  = 2'(wa);
      e.wdata  = 3'(wd);
      e.ren_n  = 5'(rn);
      e.raddr  = 2'(ra);
      e.miso_b = 8'(mb);
      e.err    = er[0];
      return e;
   endfunction

   task automatic test_reset();
      n_rst = 1'b0;
      spi_cs_n = 1'b1;
      repeat (3) @(negedge spi_sclk);
      n_checks++;
      if ({wen, r_en} !== 2'b00) $display("FAIL reset_strobes got=%b want=00", {wen, r_en});
      else n_pass++;
      n_checks++;
      if ({spi_miso, frame_err} !== 2'b00) $display("FAIL reset_miso_err got=%b want=00", {spi_miso, frame_err});
      else n_pass++;
      n_checks++;
      if ({addr, data, r_addr} !== 7'd0) $display("FAIL reset_buses got=%h want=0", {addr, data, r_addr});
      else n_pass++;
      n_rst = 1'b1;
      repeat (2) @(negedge spi_sclk);
   endtask

   task automatic test_write();
      exp_q.push_back(mk(1, 8, 1, 5, 0, 0, 0, 0));
      run_frame(8'hA5, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL write_a5 got=%p want=%p", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_read();
      ack_on = 1'b1;
      r_data = 3'd3;
      exp_q.push_back(mk(0, 0, 0, 0, 3, 1, 8'h03, 0));
      run_frame(8'h20, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL read_20 got=%p want=%p", obs, exp_r);
      else n_pass++;
      ack_on = 1'b0;
   endtask

   task automatic test_reserved();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
      exp_q.push_back(mk(1, 8, 1, 5, 0, 0, 0, 0));
      run_frame(8'h88, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL reserved_88 got=%p want=%p", obs, exp_r);
      else n_pass++;
      run_frame(8'hA5, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL err_clears got=%p want=%p", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_early_cs();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 8, 0, 1, 0, 0, 0, 0));
      run_frame(8'hA5, 5, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL early_cs got=%p want=%p", obs, exp_r);
      else n_pass++;
      run_frame(8'h81, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL write_81 got=%p want=%p", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_ack_timeout();
      ack_on = 1'b0;
      r_data = 3'd7;
      exp_q.push_back(mk(0, 0, 0, 0, 4, 2, 0, 1));
      run_frame(8'h40, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL ack_timeout got=%p want=%p", obs, exp_r);
      else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] cmd;
      cmd = 8'h40;
      ack_on = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge spi_sclk);
         spi_cs_n = 1'b0;
         spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
      end
      @(negedge spi_sclk);
      n_checks++;
      if (r_en !== 1'b1) $display("FAIL rd_wait_ren got=%b want=1", r_en);
      else n_pass++;
      #2 n_rst = 1'b0;
      #1;
      n_checks++;
      if ({wen, r_en, spi_miso, frame_err, addr, data, r_addr} !== 11'd0)
         $display("FAIL async_reset got=%h want=0", {wen, r_en, spi_miso, frame_err, addr, data, r_addr});
      else n_pass++;
      @(negedge spi_sclk);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      n_rst = 1'b1;
      repeat (2) @(negedge spi_sclk);
      ack_on = 1'b1;
      r_data = 3'd6;
      exp_q.push_back(mk(0, 0, 0, 0, 3, 3, 8'h06, 0));
      run_frame(8'h60, 16, obs);
      exp_r = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_r) $display("FAIL read_after_reset got=%p want=%p", obs, exp_r);
      else n_pass++;
      ack_on = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_reserved();
      test_early_cs();
      test_ack_timeout();
      test_reset_mid_read();
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL scoreboard_drained got=%0d want=0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
